mem_arbiter: RTL

Multi-channel successor to the single-IF/single-MEM memory controller: arbitrates `NCH` requesters onto the byte-serial unified RAM port and serialises byte/half/word loads and stores into single-byte RAM accesses. It adds a pipelined byte engine, round-robin fairness among data channels, abortable instruction fetches, and an optional tag/valid direct-mapped instruction cache with store invalidation. It sits between the fetch/LSU stages and the top-level RAM bus.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_icache.sv | 51 +++++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: length codes, FSM states, byte counting.
// MEM_ARB_ICACHE_EN adds the HIT state used by the instruction cache.
package mem_arbiter_pkg;

  localparam int ICACHE_LINES_DEF = 128;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

`ifdef MEM_ARB_ICACHE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_HIT} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_XFER} state_t;
`endif

  // Encoding 3 is reserved and behaves as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    case (len)
      LEN_BYTE: byte_count = 3'd1;
      LEN_HALF: byte_count = 3'd2;
      LEN_WORD: byte_count = 3'd4;
      default:  byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_icache.sv
// Direct-mapped one-word-per-line instruction cache, used by mem_arbiter
// only when MEM_ARB_ICACHE_EN is defined. Addresses are word addresses.
module icache_dm #(
  parameter int LINES = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [29:0] i_lk_waddr,
  output logic        o_hit,
  output logic [31:0] o_data,
  input  logic        i_fill,
  input  logic [29:0] i_fill_waddr,
  input  logic [31:0] i_fill_data,
  input  logic        i_inv,
  input  logic [29:0] i_inv_waddr
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 30 - IDXW;

  logic [LINES-1:0] r_valid;
  logic [TAGW-1:0]  r_tag  [LINES];
  logic [31:0]      r_data [LINES];
  logic [IDXW-1:0]  w_lk_idx, w_fill_idx, w_inv_idx;

  assign w_lk_idx   = i_lk_waddr[IDXW-1:0];
  assign w_fill_idx = i_fill_waddr[IDXW-1:0];
  assign w_inv_idx  = i_inv_waddr[IDXW-1:0];

  assign o_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == i_lk_waddr[29:IDXW]);
  assign o_data = r_data[w_lk_idx];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid <= '0;
    end else if (i_fill) begin
      r_valid[w_fill_idx] <= 1'b1;
    end else if (i_inv && (r_tag[w_inv_idx] == i_inv_waddr[29:IDXW])) begin
      r_valid[w_inv_idx] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them.
  always_ff @(posedge clk_in) begin
    if (i_fill) begin
      r_tag[w_fill_idx]  <= i_fill_waddr[29:IDXW];
      r_data[w_fill_idx] <= i_fill_data;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// NCH-channel arbiter serialising byte/half/word accesses onto a byte-wide RAM.
// Define MEM_ARB_ICACHE_EN to add the direct-mapped instruction cache on channel 0.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCH          = 3,
  parameter int ICACHE_LINES = ICACHE_LINES_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_wr,
  input  logic [2*NCH-1:0]  req_len,
  input  logic [32*NCH-1:0] req_addr,
  input  logic [32*NCH-1:0] req_wdata,
  output logic [NCH-1:0]    resp_valid,
  output logic [31:0]       resp_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr
);

  localparam int CHW = (NCH > 2) ? $clog2(NCH) : 1;

  state_t         r_state, w_state_nxt;
  logic [CHW-1:0] r_rr, r_ch, w_grant, w_rr_nxt;
  logic           r_wr;
  logic [2:0]     r_n, r_cyc, w_last;
  logic [31:0]    r_addr, r_wdata;
  logic           w_data_found, w_any, w_accept, w_done, w_abort;
  logic [1:0]     w_sel_len, w_rx_idx;
  logic [31:0]    w_sel_addr, w_sel_wdata, w_load_data;
  logic           w_sel_wr;

  // Round-robin search over data channels, starting at the pointer.
  always_comb begin
    int idx;
    idx          = 0;
    w_data_found = 1'b0;
    w_grant      = '0;
    for (int k = 0; k < NCH - 1; k++) begin
      idx = ((int'(r_rr) - 1 + k) % (NCH - 1)) + 1;
      if (!w_data_found && req_valid[idx]) begin
        w_data_found = 1'b1;
        w_grant      = CHW'(idx);
      end
    end
    w_any    = w_data_found || req_valid[0];
    w_rr_nxt = (int'(w_grant) == NCH - 1) ? CHW'(1) : w_grant + CHW'(1);
  end

  assign w_sel_len   = req_len[2*w_grant +: 2];
  assign w_sel_addr  = req_addr[32*w_grant +: 32];
  assign w_sel_wdata = req_wdata[32*w_grant +: 32];
  assign w_sel_wr    = (w_grant != '0) && req_wr[w_grant];

  assign w_last      = r_wr ? r_n : r_n + 3'd1;
  assign w_rx_idx    = 2'(r_cyc - 3'd2);
  assign w_load_data = resp_data | (32'(mem_din) << {w_rx_idx, 3'b000});

`ifdef MEM_ARB_ICACHE_EN
  logic        w_lk_hit, w_hit, w_cacheable_sel, r_cacheable, w_fill, w_inv;
  logic [31:0] w_hit_data;
  logic [29:0] w_lk_waddr;

  assign w_cacheable_sel = (w_grant == '0) && (byte_count(w_sel_len) == 3'd4) &&
                           (w_sel_addr[1:0] == 2'b00);
  assign w_lk_waddr      = (r_state == ST_IDLE) ? w_sel_addr[31:2] : r_addr[31:2];
  assign w_hit           = w_cacheable_sel && w_lk_hit;
  assign w_fill          = rdy_in && w_done && (r_state == ST_XFER) && r_cacheable;
  assign w_inv           = rdy_in && w_accept && w_sel_wr;

  icache_dm #(.LINES(ICACHE_LINES)) u_icache (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_lk_waddr  (w_lk_waddr),
    .o_hit       (w_lk_hit),
    .o_data      (w_hit_data),
    .i_fill      (w_fill),
    .i_fill_waddr(r_addr[31:2]),
    .i_fill_data (w_load_data),
    .i_inv       (w_inv),
    .i_inv_waddr (w_sel_addr[31:2])
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                 r_cacheable <= 1'b0;
    else if (rdy_in && w_accept) r_cacheable <= w_cacheable_sel;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((resp_valid == '0) && w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_XFER;
`ifdef MEM_ARB_ICACHE_EN
          if (w_hit) w_state_nxt = ST_HIT;
`endif
        end
      end
      ST_XFER: begin
        if ((r_ch == '0) && flush) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cyc == w_last) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef MEM_ARB_ICACHE_EN
      ST_HIT: begin
        w_abort     = flush;
        w_done      = !flush;
        w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     r_state <= ST_IDLE;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  // r_cyc counts edges since acceptance: byte k is issued at edge k, captured at k+2.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rr       <= CHW'(1);
      r_ch       <= '0;
      r_wr       <= 1'b0;
      r_n        <= 3'd0;
      r_cyc      <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      mem_dout   <= '0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
    end else if (rdy_in) begin
      resp_valid <= '0;
      if (w_accept) begin
        r_ch      <= w_grant;
        r_wr      <= w_sel_wr;
        r_n       <= byte_count(w_sel_len);
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_cyc     <= 3'd1;
        resp_data <= '0;
        mem_a     <= w_sel_addr;
        mem_wr    <= w_sel_wr;
        mem_dout  <= w_sel_wdata[7:0];
        if (w_data_found) r_rr <= w_rr_nxt;
      end else if (r_state == ST_XFER) begin
        r_cyc <= r_cyc + 3'd1;
        if (w_abort) begin
          mem_wr <= 1'b0;
        end else begin
          if (r_cyc < r_n) begin
            mem_a    <= r_addr + 32'(r_cyc);
            mem_dout <= r_wdata[{r_cyc[1:0], 3'b000} +: 8];
          end else begin
            mem_wr <= 1'b0;
          end
          if (!r_wr && (r_cyc >= 3'd2)) resp_data <= w_load_data;
          if (w_done) resp_valid[r_ch] <= 1'b1;
        end
      end
`ifdef MEM_ARB_ICACHE_EN
      else if (w_done) begin
        resp_valid[r_ch] <= 1'b1;
        resp_data        <= w_hit_data;
      end
`endif
    end
  end

endmodule
